// File: rtl/ov7670_cfg_seq.sv
// OV7670 configuration sequencer: walks a {reg addr, reg data} ROM and issues SCCB writes or ms delays.
// Define OV7670_CFG_SWRST_EN to prepend a COM7 soft-reset write and a c_swrst_ms wait. The clock is 20 ns.
module ov7670_cfg_seq #(
    parameter logic [6:0] c_cam_id     = 7'h21,
    parameter int         c_ms_endcnt  = 50000,
    parameter int         c_nb_ms_cnt  = 16,
    parameter int         c_rom_aw     = 8,
    parameter logic [7:0] c_delay_addr = 8'hF0
`ifdef OV7670_CFG_SWRST_EN
    ,
    parameter int         c_swrst_ms   = 10
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_cfg,
    output logic [c_rom_aw-1:0] rom_addr,
    input  logic [15:0]         rom_data,
    input  logic                sccb_ready,
    input  logic                sccb_finish,
    output logic                sccb_start_tx,
    output logic [6:0]          sccb_id,
    output logic [7:0]          sccb_addr,
    output logic [7:0]          sccb_data,
    output logic                cfg_busy,
    output logic                cfg_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_DEC, S_WRDY, S_WFIN, S_DLY, S_NEXT, S_DONE
    } state_t;

    // The first ms is loaded one short so the decode cycle counts toward the delay.
    localparam logic [c_nb_ms_cnt-1:0] c_cyc_reload = c_nb_ms_cnt'(c_ms_endcnt - 1);
    localparam logic [c_nb_ms_cnt-1:0] c_cyc_first  = c_nb_ms_cnt'(c_ms_endcnt - 2);

    state_t                  state_q;
    logic [c_rom_aw-1:0]     rom_addr_q;
    logic                    start_tx_q;
    logic [7:0]              sccb_addr_q;
    logic [7:0]              sccb_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic [7:0]              ms_left_q;
    logic [c_nb_ms_cnt-1:0]  cyc_q;
`ifdef OV7670_CFG_SWRST_EN
    logic                    swrst_q;
`endif

    logic at_last;
    logic is_end;
    logic is_dly;

    assign at_last = (rom_addr_q == {c_rom_aw{1'b1}});
    assign is_end  = (rom_data == 16'hFFFF);
    assign is_dly  = (rom_data[15:8] == c_delay_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            start_tx_q  <= 1'b0;
            sccb_addr_q <= 8'h00;
            sccb_data_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ms_left_q   <= 8'h00;
            cyc_q       <= '0;
`ifdef OV7670_CFG_SWRST_EN
            swrst_q     <= 1'b0;
`endif
        end else begin
            start_tx_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_cfg) begin
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        rom_addr_q <= '0;
`ifdef OV7670_CFG_SWRST_EN
                        swrst_q     <= 1'b1;
                        sccb_addr_q <= 8'h12;
                        sccb_data_q <= 8'h80;
                        state_q     <= S_WRDY;
`else
                        state_q    <= S_RD;
`endif
                    end
                end
                S_RD: state_q <= S_DEC;
                S_DEC: begin
                    if (is_end) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (is_dly) begin
                        if (rom_data[7:0] == 8'h00) begin
                            if (at_last) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                rom_addr_q <= rom_addr_q + 1'b1;
                                state_q    <= S_NEXT;
                            end
                        end else begin
                            ms_left_q <= rom_data[7:0];
                            cyc_q     <= c_cyc_first;
                            state_q   <= S_DLY;
                        end
                    end else begin
                        sccb_addr_q <= rom_data[15:8];
                        sccb_data_q <= rom_data[7:0];
                        state_q     <= S_WRDY;
                    end
                end
                S_WRDY: begin
                    if (sccb_ready) begin
                        start_tx_q <= 1'b1;
                        state_q    <= S_WFIN;
                    end
                end
                S_WFIN: begin
                    if (sccb_finish) begin
`ifdef OV7670_CFG_SWRST_EN
                        if (swrst_q) begin
                            if (c_swrst_ms == 0) begin
                                swrst_q <= 1'b0;
                                state_q <= S_RD;
                            end else begin
                                ms_left_q <= 8'(c_swrst_ms);
                                cyc_q     <= c_cyc_first;
                                state_q   <= S_DLY;
                            end
                        end else
`endif
                        if (at_last) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rom_addr_q <= rom_addr_q + 1'b1;
                            state_q    <= S_NEXT;
                        end
                    end
                end
                S_DLY: begin
                    if (cyc_q != '0) begin
                        cyc_q <= cyc_q - 1'b1;
                    end else if (ms_left_q != 8'd1) begin
                        ms_left_q <= ms_left_q - 8'd1;
                        cyc_q     <= c_cyc_reload;
                    end else
`ifdef OV7670_CFG_SWRST_EN
                    if (swrst_q) begin
                        swrst_q <= 1'b0;
                        state_q <= S_RD;
                    end else
`endif
                    if (at_last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rom_addr_q <= rom_addr_q + 1'b1;
                        state_q    <= S_NEXT;
                    end
                end
                // rom_addr was bumped on entry; this cycle covers the ROM read latency.
                S_NEXT: state_q <= S_DEC;
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr      = rom_addr_q;
    assign sccb_start_tx = start_tx_q;
    assign sccb_id       = c_cam_id;
    assign sccb_addr     = sccb_addr_q;
    assign sccb_data     = sccb_data_q;
    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q;

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Self-checking bench for ov7670_cfg_seq: registered ROM model, SCCB responder and a ROM-walk reference model.
module tb_ov7670_cfg_seq;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_cfg = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          sccb_ready;
    logic          sccb_finish;
    logic          sccb_start_tx;
    logic [6:0]    sccb_id;
    logic [7:0]    sccb_addr;
    logic [7:0]    sccb_data;
    logic          cfg_busy;
    logic          cfg_done;

    ov7670_cfg_seq #(
        .c_cam_id    (7'h21),
        .c_ms_endcnt (10),
        .c_nb_ms_cnt (16),
        .c_rom_aw    (AW),
        .c_delay_addr(8'hF0)
`ifdef OV7670_CFG_SWRST_EN
        ,
        .c_swrst_ms  (1)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_cfg    (start_cfg),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sccb_ready   (sccb_ready),
        .sccb_finish  (sccb_finish),
        .sccb_start_tx(sccb_start_tx),
        .sccb_id      (sccb_id),
        .sccb_addr    (sccb_addr),
        .sccb_data    (sccb_data),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [4];
    always @(posedge clk) rom_data <= rom[rom_addr];

    logic xfer_busy = 1'b0;
    logic ready_block = 1'b0;
    logic fin_r = 1'b0;
    logic spur_fin = 1'b0;
    assign sccb_ready  = ~xfer_busy & ~ready_block;
    assign sccb_finish = fin_r | spur_fin;

    int          fin_dly = 10;
    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    int          st_q[$];
    int          fn_q[$];
    int          extra_pulse = 0;
    int          unstable = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SCCB slave: logs each start, checks the transfer, answers with finish fin_dly clk later.
    initial begin
        forever begin
            @(negedge clk);
            if (sccb_start_tx === 1'b1) begin
                logic [15:0] held;
                logic aborted;
                held = {sccb_addr, sccb_data};
                wr_q.push_back(held);
                st_q.push_back(cyc);
                xfer_busy = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < fin_dly; k++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (sccb_start_tx !== 1'b0) extra_pulse++;
                    if ({sccb_addr, sccb_data} !== held) unstable++;
                end
                if (!aborted) begin
                    fin_r = 1'b1;
                    fn_q.push_back(cyc);
                    @(negedge clk);
                    fin_r = 1'b0;
                end
                xfer_busy = 1'b0;
            end
        end
    end

    // Reference: walk the ROM until end marker or last index, keeping only write entries.
    task automatic build_exp();
        exp_q.delete();
`ifdef OV7670_CFG_SWRST_EN
        exp_q.push_back(16'h1280);
`endif
        for (int i = 0; i < 4; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i][15:8] != 8'hF0) exp_q.push_back(rom[i]);
        end
    endtask

    task automatic check_writes(input string tag);
        build_exp();
        chk({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    endtask

    task automatic clear_log();
        wr_q.delete();
        st_q.delete();
        fn_q.delete();
    endtask

    task automatic pulse_start(output int t);
        @(negedge clk);
        start_cfg = 1'b1;
        t = cyc;
        @(negedge clk);
        start_cfg = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int d);
        d = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cfg_done) begin
                d = cyc;
                break;
            end
        end
        chk({tag, "_done"}, cfg_done, 1);
        chk({tag, "_busy"}, cfg_busy, 0);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && st_q.size() < n; k++) @(negedge clk);
        chk({tag, "_reached"}, st_q.size() >= n, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int d;
        rom[0] = 16'hFFFF; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rom_addr, sccb_start_tx, sccb_addr, sccb_data, cfg_busy, cfg_done}, 0);
        chk("sccb_id", sccb_id, 7'h21);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // two writes with slow finish, latency checks
        rom[0] = 16'h1204; rom[1] = 16'h4010; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        fin_dly = 100;
        clear_log();
        pulse_start(t0);
        wait_done("t1", 2000, d);
        check_writes("t1");
        chk("t1_id", sccb_id, 7'h21);
`ifndef OV7670_CFG_SWRST_EN
        if (st_q.size() >= 1) chk("t1_start_lat", st_q[0] - t0, 4);
`endif
        if (st_q.size() >= 2 && fn_q.size() >= st_q.size() - 1)
            chk("t1_fin_to_start", st_q[st_q.size()-1] - fn_q[st_q.size()-2], 4);

        // pure delay of 3 ms
        rom[0] = 16'hF003; rom[1] = 16'hFFFF; rom[2] = 16'h0000; rom[3] = 16'h0000;
        fin_dly = 5;
        clear_log();
        pulse_start(t0);
        wait_done("t2", 2000, d);
        check_writes("t2");
`ifndef OV7670_CFG_SWRST_EN
        chk("t2_delay_window", (d - (t0 + 3) >= 28) && (d - (t0 + 3) <= 32), 1);
`endif

        // ready held low, spurious finish during WRDY
        rom[0] = 16'h1204; rom[1] = 16'h4010; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        fin_dly = 8;
        ready_block = 1'b1;
        clear_log();
        pulse_start(t0);
        repeat (20) @(negedge clk);
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        repeat (29) @(negedge clk);
        chk("t3_held_off", st_q.size(), 0);
        chk("t3_still_busy", cfg_busy, 1);
        ready_block = 1'b0;
        wait_done("t3", 2000, d);
        check_writes("t3");

        // reset during WFIN of the second entry, then restart
        fin_dly = 100;
        clear_log();
        build_exp();
        pulse_start(t0);
        wait_starts("t4_second_write", exp_q.size(), 2000);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_abort_state", {rom_addr, sccb_start_tx, sccb_addr, sccb_data, cfg_busy, cfg_done}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        pulse_start(t0);
        wait_done("t4", 2000, d);
        check_writes("t4");

        // no end marker: runs off the last index; start while busy is ignored
        rom[0] = 16'h1100; rom[1] = 16'h1100; rom[2] = 16'h1100; rom[3] = 16'h1100;
        fin_dly = 6;
        clear_log();
        pulse_start(t0);
        wait_starts("t5_two_writes", 2, 2000);
        pulse_start(t0);
        wait_done("t5", 2000, d);
        check_writes("t5");
        chk("t5_last_addr", rom_addr, 2'd3);

        // randomized ROM contents and SCCB timing
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin
                int r;
                logic [7:0] a;
                logic [7:0] dd;
                r = $urandom_range(0, 5);
                a = 8'($urandom_range(0, 255));
                dd = 8'($urandom_range(0, 255));
                if (r == 0) rom[i] = 16'hFFFF;
                else if (r == 1) rom[i] = {8'hF0, 8'($urandom_range(0, 3))};
                else begin
                    if (a == 8'hF0) a = 8'hF1;
                    if (a == 8'hFF && dd == 8'hFF) dd = 8'hFE;
                    rom[i] = {a, dd};
                end
            end
            fin_dly = $urandom_range(1, 20);
            clear_log();
            pulse_start(t0);
            wait_done($sformatf("rnd%0d", it), 3000, d);
            check_writes($sformatf("rnd%0d", it));
        end

        chk("no_extra_start_pulse", extra_pulse, 0);
        chk("addr_data_stable", unstable, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ov7670_cfg_seq.md
Name: ov7670_cfg_seq

Overview:
- Configuration sequencer for the OV7670 camera. It sits between a configuration ROM and the SCCB write master.
- Walks the ROM of {register address, data} words. For each word it issues one 3-phase SCCB write, or a millisecond delay, and waits for completion before moving on.
- Raises `cfg_done` when the end marker is reached. The pixel capture path uses `cfg_done` to know the camera is configured.

Parameters:
- `c_cam_id`, 7'h21, 7-bit SCCB slave ID (write address 0x42).
- `c_clk_period`, 20, fpga clk period in ns (informative).
- `c_ms_endcnt`, 50000, clk cycles per millisecond (1 ms / 20 ns).
- `c_nb_ms_cnt`, 16, width of the ms cycle counter.
- `c_rom_aw`, 8, ROM address width. This is also the maximum entry count, 2**c_rom_aw.
- `c_delay_addr`, 8'hF0, ROM address-field marker meaning "delay data ms".
- `c_swrst_ms`, 10, wait after the soft reset (optional feature only).

Ports:
- `clk`  in  1  fpga clock
- `rst`  in  1  asynchronous reset, active-low (rst=0 resets)
- `start_cfg`  in  1  start/restart the configuration (level or pulse)
- `rom_addr`  out  c_rom_aw  ROM index; read data valid 1 clk later
- `rom_data`  in  16  {reg addr[15:8], reg data[7:0]}
- `sccb_ready`  in  1  ready from the SCCB master
- `sccb_finish`  in  1  1-cycle finish pulse from the SCCB master
- `sccb_start_tx`  out  1  1-cycle start pulse to the SCCB master
- `sccb_id`  out  7  constant c_cam_id
- `sccb_addr`  out  8  register address, held stable from start until finish
- `sccb_data`  out  8  register data, held stable from start until finish
- `cfg_busy`  out  1  sequence in progress
- `cfg_done`  out  1  sequence complete; held until next start_cfg or reset

Behaviour:
- Reset values:
  - state IDLE
  - `rom_addr`=0, `sccb_start_tx`=0, `sccb_addr`=0, `sccb_data`=0
  - `cfg_busy`=0, `cfg_done`=0
  - ms counters cleared
- ROM word decode:
  - 16'hFFFF: end marker.
  - addr == c_delay_addr: delay of data ms. data=0 gives no wait.
  - Anything else: SCCB write of data to addr.
- States:
  - IDLE: when start_cfg=1 → clear cfg_done, set cfg_busy, set rom_addr=0, go to RD.
  - RD: wait 1 clk for ROM latency → DEC.
  - DEC:
    - end marker → DONE.
    - delay entry → DLY, loading the ms count from data. If data=0, go straight to NEXT.
    - write entry → latch sccb_addr/sccb_data, go to WRDY.
  - WRDY: wait for sccb_ready=1. Then assert sccb_start_tx for exactly 1 clk → WFIN.
  - WFIN: wait for sccb_finish=1 → NEXT. start_tx is never reasserted in WFIN.
  - DLY: counts c_ms_endcnt clk per ms until the ms count is exhausted → NEXT. Delay of N ms = N*c_ms_endcnt clk ±2.
  - NEXT:
    - If rom_addr == 2**c_rom_aw-1 → DONE. No wrap: a ROM without an end marker terminates.
    - Otherwise increment rom_addr → RD.
  - DONE: cfg_busy=0, cfg_done=1 → IDLE.
- `start_cfg` while busy is ignored. After DONE, a start_cfg that is still high restarts the sequence.
- `rst` asserted mid-sequence aborts immediately and all outputs return to reset values. An SCCB transfer in flight is abandoned; the master is reset by the same reset.
- `sccb_finish` outside WFIN is ignored.
- Latency:
  - start_cfg to the first sccb_start_tx is 4 clk when sccb_ready is already 1.
  - sccb_finish to the next sccb_start_tx is 4 clk.

Optional Feature:
- Macro: `OV7670_CFG_SWRST_EN`.
- When defined, on start_cfg the sequencer first writes COM7 (addr 8'h12, data 8'h80, camera soft reset). It then waits c_swrst_ms ms, then begins at rom_addr=0.
- When not defined, the sequence begins directly at rom_addr=0. No implicit writes occur.

Test Plan:
- ROM {0x1204, 0x4010, 0xFFFF}, instant-ready SCCB model with finish 100 clk after start → exactly two start pulses, addr/data 0x12/0x04 then 0x40/0x10, sccb_id=0x21, then cfg_done=1 and cfg_busy=0.
- ROM {0xF003, 0xFFFF}, c_ms_endcnt=10 → no sccb_start_tx, cfg_done 30±2 clk after the delay decode.
- sccb_ready held 0 for 50 clk → sccb_start_tx is held off until ready=1, then pulses for 1 clk only. A spurious sccb_finish during WRDY has no effect.
- rst=0 asserted during WFIN of the 2nd entry, then released and start_cfg given → rom_addr restarts at 0, the first write is 0x12/0x04, cfg_done ends 0 then 1.
- ROM with no end marker, c_rom_aw=2, all entries 0x1100 → exactly 4 writes, then cfg_done. A start_cfg pulse while busy causes no restart.
- With OV7670_CFG_SWRST_EN, c_swrst_ms=1, c_ms_endcnt=10 → first write is 0x12/0x80, ~10 clk wait, then ROM entry 0.
